// File: rtl/frame_pkg.sv
// Shared types and constants for the frame sequencer and the 60 Hz divider.
package frame_pkg;

  // Per-frame phase sequence.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ERASE  = 2'd1,
    UPDATE = 2'd2,
    DRAW   = 2'd3
  } frame_state_e;

  localparam int unsigned FRAMES_PER_SEC_DEFAULT = 60;

  // Divider reload for a 60 Hz tick from the 50 MHz system clock.
  localparam int unsigned TICK_LOAD_60HZ = 833333;

endpackage : frame_pkg

// File: rtl/frame_timebase.sv
// Sub-frame counter and seconds counter, advanced once per completed frame.
module frame_timebase
  import frame_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = FRAMES_PER_SEC_DEFAULT,
  parameter int unsigned SEC_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_done_i,
  output logic [SEC_W-1:0] seconds_o,
  output logic             sec_pulse_o
);

  localparam int unsigned SUB_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(FRAMES_PER_SEC - 1);

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             pulse_q, pulse_d;

  // Count frames within the second; roll over into seconds on the last one.
  always_comb begin
    sub_d   = sub_q;
    sec_d   = sec_q;
    pulse_d = 1'b0;
    if (frame_done_i) begin
      if (sub_q == SUB_LAST) begin
        sub_d   = '0;
        sec_d   = sec_q + SEC_W'(1);
        pulse_d = 1'b1;
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  // Timebase registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sub_q   <= '0;
      sec_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sub_q   <= sub_d;
      sec_q   <= sec_d;
      pulse_q <= pulse_d;
    end
  end

  assign seconds_o   = sec_q;
  assign sec_pulse_o = pulse_q;

endmodule : frame_timebase

// File: rtl/frame_sequencer.sv
// Turns each accepted frame tick into an ordered erase/update/draw handshake.
module frame_sequencer
  import frame_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = FRAMES_PER_SEC_DEFAULT,
  parameter int unsigned FRAME_W        = 16,
  parameter int unsigned SEC_W          = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               tick,
  input  logic               erase_done,
  input  logic               update_done,
  input  logic               draw_done,
  output logic               erase_start,
  output logic               update_start,
  output logic               draw_start,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_count,
  output logic [SEC_W-1:0]   seconds,
  output logic               sec_pulse,
  output logic               overrun
);

  frame_state_e       state_q, state_d;
  logic               erase_start_q, erase_start_d;
  logic               update_start_q, update_start_d;
  logic               draw_start_q, draw_start_d;
  logic               busy_q, busy_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               overrun_q, overrun_d;
  logic               frame_done_c;

  // Phase sequencing; each done is honoured only in its own phase.
  always_comb begin
    state_d        = state_q;
    erase_start_d  = 1'b0;
    update_start_d = 1'b0;
    draw_start_d   = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    overrun_d      = overrun_q;
    frame_done_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick && enable) begin
          state_d       = ERASE;
          erase_start_d = 1'b1;
        end
      end
      ERASE: begin
        if (erase_done) begin
          state_d        = UPDATE;
          update_start_d = 1'b1;
        end
      end
      UPDATE: begin
        if (update_done) begin
          state_d      = DRAW;
          draw_start_d = 1'b1;
        end
      end
      DRAW: begin
        if (draw_done) begin
          state_d      = IDLE;
          frame_cnt_d  = frame_cnt_q + FRAME_W'(1);
          frame_done_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An accepted tick while a frame is in flight (even on its last cycle) is lost.
    if (tick && enable && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      erase_start_q  <= 1'b0;
      update_start_q <= 1'b0;
      draw_start_q   <= 1'b0;
      busy_q         <= 1'b0;
      frame_cnt_q    <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      erase_start_q  <= erase_start_d;
      update_start_q <= update_start_d;
      draw_start_q   <= draw_start_d;
      busy_q         <= busy_d;
      frame_cnt_q    <= frame_cnt_d;
      overrun_q      <= overrun_d;
    end
  end

  frame_timebase #(
    .FRAMES_PER_SEC (FRAMES_PER_SEC),
    .SEC_W          (SEC_W)
  ) u_timebase (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_done_i (frame_done_c),
    .seconds_o    (seconds),
    .sec_pulse_o  (sec_pulse)
  );

  assign erase_start  = erase_start_q;
  assign update_start = update_start_q;
  assign draw_start   = draw_start_q;
  assign busy         = busy_q;
  assign frame_count  = frame_cnt_q;
  assign overrun      = overrun_q;

endmodule : frame_sequencer
